// File: rtl/sym_dn_lut_bank.sv
// Double-buffered decision-node LUT: a streaming loader fills the shadow bank
// while RD_PORTS registered read ports serve the active bank; swap commits it.
//
// state | meaning
// IDLE  | waiting for load_start; swap_req honoured when shadow_full
// LOAD  | accepting load_data into shadow bank, address 0..DEPTH-1
module sym_dn_lut_bank #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 7,
    parameter int RD_PORTS = 2
) (
    input  logic                         write_clk,
    input  logic                         rstn,
    input  logic                         load_start,
    input  logic [DATA_W-1:0]            load_data,
    input  logic                         load_valid,
    output logic                         load_ready,
    output logic                         load_done,
    output logic                         shadow_full,
    input  logic                         swap_req,
    output logic                         active_bank,
    output logic                         lut_ready,
    output logic                         busy,
    input  logic [RD_PORTS-1:0]          rd_en,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]          rd_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_W-1:0]            cnt_q, cnt_d;
    logic                         load_done_q, load_done_d;
    logic                         shadow_full_q, shadow_full_d;
    logic                         active_bank_q, active_bank_d;
    logic                         lut_ready_q, lut_ready_d;
    logic [RD_PORTS-1:0]          rd_valid_q, rd_valid_d;
    logic [RD_PORTS*DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                         wr_en;

    logic [DATA_W-1:0] bank_mem [2][DEPTH];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        load_done_d   = 1'b0;
        shadow_full_d = shadow_full_q;
        active_bank_d = active_bank_q;
        lut_ready_d   = lut_ready_q;
        wr_en         = 1'b0;
        case (state_q)
            IDLE: begin
                if (shadow_full_q && swap_req) begin
                    active_bank_d = ~active_bank_q;
                    shadow_full_d = 1'b0;
                    lut_ready_d   = 1'b1;
                end
                // Starting a load discards any uncommitted table.
                if (load_start) begin
                    state_d       = LOAD;
                    cnt_d         = '0;
                    shadow_full_d = 1'b0;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (&cnt_q) begin
                        load_done_d   = 1'b1;
                        shadow_full_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        for (int p = 0; p < RD_PORTS; p++) begin
            if (rd_en[p])
                rd_data_d[p*DATA_W +: DATA_W] =
                    bank_mem[active_bank_q][rd_addr[p*ADDR_W +: ADDR_W]];
        end
    end

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            load_done_q   <= 1'b0;
            shadow_full_q <= 1'b0;
            active_bank_q <= 1'b0;
            lut_ready_q   <= 1'b0;
            rd_valid_q    <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            load_done_q   <= load_done_d;
            shadow_full_q <= shadow_full_d;
            active_bank_q <= active_bank_d;
            lut_ready_q   <= lut_ready_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Loads only happen in LOAD, so the inactive bank is always the shadow.
    always_ff @(posedge write_clk) begin
        if (wr_en)
            bank_mem[~active_bank_q][cnt_q] <= load_data;
    end

    assign load_ready  = (state_q == LOAD);
    assign busy        = (state_q == LOAD);
    assign load_done   = load_done_q;
    assign shadow_full = shadow_full_q;
    assign active_bank = active_bank_q;
    assign lut_ready   = lut_ready_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;

endmodule
